mux_scan_nx1: RTL and testbench
===============================

Name: mux_scan_nx1

Overview:
Parametrised, registered N-to-1 multiplexer and the successor to the combinational 8x1 mux. It has two modes. Manual mode passes the externally selected channel. Scan mode steps through enabled channels on its own for time-division sampling of a channel bank. The output is registered with a valid flag, a selected-channel tag and a frame-start marker, so downstream samplers can deserialise the stream.

Parameters:
WIDTH, 1, bit width of each channel
CHANNELS, 8, number of input channels (2..64; need not be a power of 2)
SEL_W, $clog2(CHANNELS), select/tag width (derived, not overridden)
DWELL, 1, cycles spent on each channel in scan mode (1..256)

Ports:
clk  in  1  single clock; all state on rising edge
rst  in  1  reset, synchronous and active-high
in  in  CHANNELS*WIDTH  packed channels; channel k = in[k*WIDTH +: WIDTH]
en  in  1  advance/update enable
mode  in  1  0 = manual, 1 = scan
sel  in  SEL_W  manual-mode channel select
ch_mask  in  CHANNELS  1 = channel enabled for scan; ignored in manual mode
out_data  out  WIDTH  registered selected channel data
out_sel  out  SEL_W  channel index that out_data came from
out_valid  out  1  out_data/out_sel valid this cycle
frame_start  out  1  first beat of a scan pass
sel_err  out  1  manual sel >= CHANNELS (registered)

Behaviour:
- Reset (rst=1 at an edge) forces:
  - out_data=0, out_sel=0, out_valid=0, frame_start=0, sel_err=0
  - cur_ch=0, dwell_cnt=0, state=MANUAL
- Reset has priority over every other input, including mid-scan.
- Latency: one cycle. Inputs sampled at edge t appear on the outputs after edge t.
- en=0:
  - All counters and the state are frozen.
  - out_valid=0 and frame_start=0.
  - out_data, out_sel and sel_err hold their values.
- State machine: MANUAL, SCAN. Transitions are evaluated only when en=1.
  - MANUAL -> SCAN when mode=1. Scan restarts at the lowest set bit of ch_mask, with dwell_cnt=0.
  - SCAN -> MANUAL when mode=0. The manual select takes effect in that same cycle.
- MANUAL, en=1, sel < CHANNELS: out_data=in[sel], out_sel=sel, out_valid=1, sel_err=0.
- MANUAL, en=1, sel >= CHANNELS: out_data=0, out_sel=sel, out_valid=0, sel_err=1.
- SCAN, en=1, ch_mask != 0:
  - Each cycle: out_data=in[cur_ch], out_sel=cur_ch, out_valid=1.
  - While dwell_cnt < DWELL-1, dwell_cnt increments.
  - Otherwise dwell_cnt=0 and cur_ch moves to the next set mask bit above cur_ch. The search wraps to the lowest set bit and is resolved in the same cycle, so masked channels cost no cycles.
- frame_start=1 only when all of these hold:
  - the beat is the first dwell cycle, and
  - cur_ch is the lowest set bit of ch_mask, and
  - the beat follows entry into SCAN or a wrap.
- Single enabled channel: every DWELL-th beat carries frame_start.
- ch_mask==0 in SCAN: out_valid=0, frame_start=0, counters held, out_data holds.
- ch_mask changes mid-scan:
  - The change takes effect at the next channel advance.
  - If the current channel is now masked, it finishes its dwell first.
- DWELL=1: the channel advances every enabled cycle.
- sel_err is 0 throughout SCAN.
- Data and mask arithmetic are unsigned. cur_ch never exceeds CHANNELS-1.

Decomposition:
- Package mux_pkg:
  - state enum {MANUAL, SCAN}
  - function next_set_bit(mask, cur) returning the wrap-around index plus a wrap flag
  - function lowest_set_bit(mask)
- Sub-module mux_scan_seq (state register, cur_ch, dwell_cnt, frame_start logic).
- The top level instantiates mux_scan_seq and holds the indexed part-select and output registers.

Test Plan:
- Manual mode, CHANNELS=8, WIDTH=1, in=8'b1010_0110, sel stepped 0..7 at 10-cycle spacing:
  - out_data one cycle later = 0,1,1,0,0,1,0,1
  - out_valid=1 and out_sel matches sel
- CHANNELS=6, manual mode, sel=6:
  - sel_err=1, out_valid=0, out_data=0
  - then sel=5 -> sel_err=0, out_data=in[5]
- Scan mode, WIDTH=4, DWELL=1, ch_mask=8'hFF, in[k]=k:
  - out_data=0,1,...,7,0,...
  - frame_start=1 on every out_sel=0 beat
- Scan mode, DWELL=3, ch_mask=8'b0010_0101:
  - out_sel sequence 0,0,0,2,2,2,5,5,5,0...
  - frame_start on the first 0 beat of each pass only
- Scan mode, mask=0:
  - out_valid stays 0
  - setting mask=8'h10 -> out_sel=4 with frame_start=1 on the first valid beat
- Reset and enable mid-operation:
  - assert rst at out_sel=3 mid-dwell -> next cycle all outputs 0
  - hold en=0 for 5 cycles mid-scan -> out_valid=0, then resume at the same cur_ch and dwell_cnt

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared state type and channel-search helpers for the scanning mux
package mux_pkg;

  localparam int MAX_CH = 64;
  localparam int IDX_W  = 6;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_e;

  typedef struct packed {
    logic             wrap;
    logic [IDX_W-1:0] idx;
  } next_t;

  function automatic logic [IDX_W-1:0] lowest_set_bit(input logic [MAX_CH-1:0] mask);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Lowest set bit strictly above cur; if none, wrap to the lowest set bit overall.
  function automatic next_t next_set_bit(input logic [MAX_CH-1:0] mask,
                                         input logic [IDX_W-1:0]  cur);
    next_t r;
    r.wrap = 1'b1;
    r.idx  = lowest_set_bit(mask);
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i] && (IDX_W'(i) > cur)) begin
        r.idx  = IDX_W'(i);
        r.wrap = 1'b0;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_seq.sv
// rtl/mux_scan_seq.sv - manual/scan state, channel pointer, dwell counter and frame marker
module mux_scan_seq
  import mux_pkg::*;
#(
  parameter int CHANNELS = 8,
  parameter int SEL_W    = 3,
  parameter int DWELL    = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic                mode_i,
  input  logic [CHANNELS-1:0] ch_mask_i,
  output logic                beat_o,
  output logic [SEL_W-1:0]    beat_ch_o,
  output logic                frame_o
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_q, cur_d, eff_cur, low_ch;
  logic [7:0]       dwell_q, dwell_d, eff_dwell;
  logic             pass_q, pass_d, restart_q, restart_d;
  logic             entry, eff_first;
  logic [MAX_CH-1:0] mask;
  next_t            nxt;

  // A scan entered with an empty mask restarts from scratch once channels appear.
  assign mask      = MAX_CH'(ch_mask_i);
  assign low_ch    = lowest_set_bit(mask);
  assign entry     = (state_q == MANUAL) || restart_q;
  assign eff_cur   = entry ? low_ch : cur_q;
  assign eff_dwell = entry ? 8'd0 : dwell_q;
  assign eff_first = entry || pass_q;
  assign nxt       = next_set_bit(mask, eff_cur);
  assign beat_ch_o = SEL_W'(eff_cur);

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    dwell_d   = dwell_q;
    pass_d    = pass_q;
    restart_d = restart_q;
    beat_o    = 1'b0;
    frame_o   = 1'b0;
    if (en_i) begin
      if (!mode_i) begin
        state_d   = MANUAL;
        restart_d = 1'b0;
      end else begin
        state_d = SCAN;
        if (mask == '0) begin
          if (state_q == MANUAL) restart_d = 1'b1;
        end else begin
          beat_o    = 1'b1;
          restart_d = 1'b0;
          frame_o   = (eff_dwell == 8'd0) && eff_first && (eff_cur == low_ch);
          if (eff_dwell < DWELL_LAST) begin
            dwell_d = eff_dwell + 8'd1;
            cur_d   = eff_cur;
            pass_d  = eff_first;
          end else begin
            dwell_d = 8'd0;
            cur_d   = nxt.idx;
            pass_d  = nxt.wrap;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= MANUAL;
      cur_q     <= '0;
      dwell_q   <= '0;
      pass_q    <= 1'b0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      dwell_q   <= dwell_d;
      pass_q    <= pass_d;
      restart_q <= restart_d;
    end
  end

endmodule

// File: rtl/mux_scan_nx1.sv
// rtl/mux_scan_nx1.sv - registered N-to-1 mux with manual select and masked auto-scan
module mux_scan_nx1
  import mux_pkg::*;
#(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DWELL    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic                      en,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS-1:0]       ch_mask,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  output logic                      frame_start,
  output logic                      sel_err
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W + 1)'(CHANNELS);

  logic [WIDTH-1:0] chan [CHANNELS];
  logic             beat, frame, sel_ok;
  logic [SEL_W-1:0] beat_ch;
  logic [WIDTH-1:0] data_d, data_q;
  logic [SEL_W-1:0] osel_d, osel_q;
  logic             valid_d, valid_q, frame_d, frame_q, err_d, err_q;

  for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
    assign chan[k] = in[k*WIDTH +: WIDTH];
  end

  mux_scan_seq #(
    .CHANNELS (CHANNELS),
    .SEL_W    (SEL_W),
    .DWELL    (DWELL)
  ) u_seq (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .mode_i    (mode),
    .ch_mask_i (ch_mask),
    .beat_o    (beat),
    .beat_ch_o (beat_ch),
    .frame_o   (frame)
  );

  assign sel_ok = {1'b0, sel} < CH_LIM;

  always_comb begin
    data_d  = data_q;
    osel_d  = osel_q;
    err_d   = err_q;
    valid_d = 1'b0;
    frame_d = 1'b0;
    if (en) begin
      if (mode) begin
        err_d = 1'b0;
        if (beat) begin
          data_d  = chan[beat_ch];
          osel_d  = beat_ch;
          valid_d = 1'b1;
          frame_d = frame;
        end
      end else begin
        osel_d = sel;
        err_d  = !sel_ok;
        if (sel_ok) begin
          data_d  = chan[sel];
          valid_d = 1'b1;
        end else begin
          data_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      osel_q  <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      osel_q  <= osel_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
      err_q   <= err_d;
    end
  end

  assign out_data    = data_q;
  assign out_sel     = osel_q;
  assign out_valid   = valid_q;
  assign frame_start = frame_q;
  assign sel_err     = err_q;

endmodule

// File: tb/tb_mux_scan_nx1.sv
// tb/tb_mux_scan_nx1.sv - vector-table bench for mux_scan_nx1 (8ch/DWELL=1 and 6ch/DWELL=3)
module tb_mux_scan_nx1;

  typedef struct {
    bit         which;
    bit         rst;
    bit         en;
    bit         mode;
    logic [2:0] sel;
    logic [7:0] mask;
    bit         pat;
    bit         ev;
    logic [2:0] es;
    logic [3:0] ed;
    bit         ef;
    bit         ee;
  } vec_t;

  localparam logic [31:0] RAMP_IN = {4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [31:0] PAT_IN  = {4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1, 4'd1, 4'd0};
  localparam logic [23:0] B_IN    = {4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9};

  logic        clk;
  logic        rst_a, en_a, mode_a, rst_b, en_b, mode_b;
  logic [31:0] in_a;
  logic [23:0] in_b;
  logic [2:0]  sel_a, sel_b, osel_a, osel_b;
  logic [7:0]  mask_a;
  logic [5:0]  mask_b;
  logic [3:0]  data_a, data_b;
  logic        valid_a, valid_b, frame_a, frame_b, err_a, err_b;

  int   errors = 0;
  int   checks = 0;
  vec_t tbl[$];
  vec_t sb_q[$];

  mux_scan_nx1 #(.WIDTH(4), .CHANNELS(8), .DWELL(1)) dut_a (
    .clk(clk), .rst(rst_a), .in(in_a), .en(en_a), .mode(mode_a), .sel(sel_a),
    .ch_mask(mask_a), .out_data(data_a), .out_sel(osel_a), .out_valid(valid_a),
    .frame_start(frame_a), .sel_err(err_a)
  );

  mux_scan_nx1 #(.WIDTH(4), .CHANNELS(6), .DWELL(3)) dut_b (
    .clk(clk), .rst(rst_b), .in(in_b), .en(en_b), .mode(mode_b), .sel(sel_b),
    .ch_mask(mask_b), .out_data(data_b), .out_sel(osel_b), .out_valid(valid_b),
    .frame_start(frame_b), .sel_err(err_b)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  function automatic vec_t mk(bit w, bit r, bit e, bit m, int s, int msk, bit p,
                              bit ev, int es, int ed, bit ef, bit ee);
    vec_t v;
    v.which = w;  v.rst = r;  v.en = e;  v.mode = m;
    v.sel = 3'(s);  v.mask = 8'(msk);  v.pat = p;
    v.ev = ev;  v.es = 3'(es);  v.ed = 4'(ed);  v.ef = ef;  v.ee = ee;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic step(input vec_t v, input int idx);
    vec_t e;
    if (!v.which) begin
      rst_a = v.rst;  en_a = v.en;  mode_a = v.mode;  sel_a = v.sel;  mask_a = v.mask;
      in_a  = v.pat ? PAT_IN : RAMP_IN;
      rst_b = 1'b0;  en_b = 1'b0;
    end else begin
      rst_b = v.rst;  en_b = v.en;  mode_b = v.mode;  sel_b = v.sel;  mask_b = v.mask[5:0];
      rst_a = 1'b0;  en_a = 1'b0;
    end
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    if (!e.which) begin
      chk("a_valid", idx, 8'(valid_a), 8'(e.ev));
      chk("a_sel",   idx, 8'(osel_a),  8'(e.es));
      chk("a_data",  idx, 8'(data_a),  8'(e.ed));
      chk("a_frame", idx, 8'(frame_a), 8'(e.ef));
      chk("a_err",   idx, 8'(err_a),   8'(e.ee));
    end else begin
      chk("b_valid", idx, 8'(valid_b), 8'(e.ev));
      chk("b_sel",   idx, 8'(osel_b),  8'(e.es));
      chk("b_data",  idx, 8'(data_b),  8'(e.ed));
      chk("b_frame", idx, 8'(frame_b), 8'(e.ef));
      chk("b_err",   idx, 8'(err_b),   8'(e.ee));
    end
  endtask

  initial begin
    logic [7:0] pd;
    clk = 1'b0;
    rst_a = 1'b1;  en_a = 1'b0;  mode_a = 1'b0;  sel_a = '0;  mask_a = '0;  in_a = RAMP_IN;
    rst_b = 1'b1;  en_b = 1'b0;  mode_b = 1'b0;  sel_b = '0;  mask_b = '0;  in_b = B_IN;
    pd = 8'b1010_0110;

    // 8 channels, DWELL=1: reset, manual walk, scan over all, freeze, empty-mask restart
    tbl.push_back(mk(0, 1, 1, 0, 0, 'h00, 1,  0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 0, 1, 0, k, 'h00, 1,  1, k, int'(pd[k]), 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 2, 'h00, 1,  0, 7, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'hFF, 0,  1, 0, 0, 1, 0));
    for (int k = 1; k < 8; k++) tbl.push_back(mk(0, 0, 1, 1, 0, 'hFF, 0,  1, k, k, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'hFF, 0,  1, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'hFF, 0,  1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'hFF, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 'hFF, 0,  0, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'hFF, 0,  1, 2, 2, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0, 5, 'hFF, 0,  1, 5, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 5, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h00, 0,  0, 5, 5, 0, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h10, 0,  1, 4, 4, 1, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0, 'h10, 0,  1, 4, 4, 1, 0));

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);

    // 6 channels, DWELL=3, in[k]=k+9: bad select, dwell, freeze, mask change, mid-dwell reset
    step(mk(1, 1, 1, 0, 0, 'h00, 0,  0, 0, 0,  0, 0), 100);
    step(mk(1, 0, 1, 0, 6, 'h00, 0,  0, 6, 0,  0, 1), 101);
    step(mk(1, 0, 1, 0, 7, 'h00, 0,  0, 7, 0,  0, 1), 102);
    step(mk(1, 0, 0, 0, 3, 'h00, 0,  0, 7, 0,  0, 1), 103);
    step(mk(1, 0, 1, 0, 5, 'h00, 0,  1, 5, 14, 0, 0), 104);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 0, 9,  1, 0), 105);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 0, 9,  0, 0), 106);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 0, 9,  0, 0), 107);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 2, 11, 0, 0), 108);
    for (int k = 0; k < 5; k++) step(mk(1, 0, 0, 1, 0, 'h25, 0,  0, 2, 11, 0, 0), 110 + k);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 2, 11, 0, 0), 120);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 2, 11, 0, 0), 121);
    step(mk(1, 0, 1, 1, 0, 'h25, 0,  1, 5, 14, 0, 0), 122);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 5, 14, 0, 0), 123);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 5, 14, 0, 0), 124);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 0, 9,  1, 0), 125);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 0, 9,  0, 0), 126);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 0, 9,  0, 0), 127);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 3, 12, 0, 0), 128);
    step(mk(1, 1, 1, 1, 0, 'h09, 0,  0, 0, 0,  0, 0), 129);
    step(mk(1, 0, 1, 1, 0, 'h09, 0,  1, 0, 9,  1, 0), 130);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
